// File: rtl/conv_bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package conv_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } estado_t;

    localparam logic [3:0] ADD3   = 4'd3;
    localparam logic [3:0] LIMIAR = 4'd5;

    localparam int BIN_W_DEF  = 8;
    localparam int DIGITS_DEF = 3;

    // Counter must hold the value BIN_W itself.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/ajuste_dabble_digito.sv
// Per-digit double-dabble correction: a digit of 5..15 gets +3 (4-bit wrap) before the shift.
module ajuste_dabble_digito
    import conv_bcd_pkg::*;
(
    input  logic [3:0] digito_i,
    output logic [3:0] digito_o
);

    // +3 makes the following left shift carry into the next decimal digit
    always_comb begin
        if (digito_i >= LIMIAR) begin
            digito_o = digito_i + ADD3;
        end else begin
            digito_o = digito_i;
        end
    end

endmodule

// File: rtl/conversor_bin_bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Optional overflow flag (estouro) is enabled by defining CONV_BCD_OVF_EN.
module conversor_bin_bcd_seq
    import conv_bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inicio,
    input  logic [BIN_W-1:0]      entrada,
    output logic                  ocupado,
    output logic                  pronto,
`ifdef CONV_BCD_OVF_EN
    output logic                  estouro,
`endif
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int W  = 4 * DIGITS + BIN_W;
    localparam int CW = cnt_width(BIN_W);

    estado_t               estado_q;
    logic [W-1:0]          sr_q;
    logic [W-1:0]          ajustado_s;
    logic [W-1:0]          sr_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  ocupado_q;
    logic                  pronto_q;
    logic [4*DIGITS-1:0]   bcd_q;

    assign ajustado_s[BIN_W-1:0] = sr_q[BIN_W-1:0];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digito
        ajuste_dabble_digito u_ajuste (
            .digito_i (sr_q[BIN_W + 4*k +: 4]),
            .digito_o (ajustado_s[BIN_W + 4*k +: 4])
        );
    end

    // The top bit falls off here; it is only observed by the overflow flag.
    assign sr_d  = ajustado_s << 1;
    assign cnt_d = cnt_q - CW'(1);

    // Control FSM with the shift register, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            bcd_q     <= '0;
        end else begin
            case (estado_q)
                IDLE: begin
                    if (inicio) begin
                        sr_q      <= {{(4*DIGITS){1'b0}}, entrada};
                        cnt_q     <= CW'(BIN_W);
                        ocupado_q <= 1'b1;
                        estado_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == CW'(1)) begin
                        bcd_q     <= sr_d[W-1 -: 4*DIGITS];
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= DONE;
                    end
                end
                DONE: begin
                    pronto_q <= 1'b0;
                    estado_q <= IDLE;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    pronto_q  <= 1'b0;
                    estado_q  <= IDLE;
                end
            endcase
        end
    end

    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;
    assign bcd     = bcd_q;

`ifdef CONV_BCD_OVF_EN
    logic estouro_q;

    // Sticky flag for any 1 bit leaving the top digit during a conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estouro_q <= 1'b0;
        end else if ((estado_q == IDLE) && inicio) begin
            estouro_q <= 1'b0;
        end else if ((estado_q == SHIFT) && ajustado_s[W-1]) begin
            estouro_q <= 1'b1;
        end
    end

    assign estouro = estouro_q;
`endif

endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// Self-checking bench: 8-bit and 10-bit converters against a decimal-digit reference model.
module tb_conversor_bin_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        inicio8, inicio10;
    logic [7:0]  entrada8;
    logic [9:0]  entrada10;
    logic        ocupado8, ocupado10;
    logic        pronto8, pronto10;
    logic        estouro8, estouro10;
    logic [11:0] bcd8, bcd10;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp8_q[$];
    logic [11:0] exp10_q[$];
    logic        ovf10_q[$];

    conversor_bin_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio8),
        .entrada (entrada8),
        .ocupado (ocupado8),
        .pronto  (pronto8),
`ifdef CONV_BCD_OVF_EN
        .estouro (estouro8),
`endif
        .bcd     (bcd8)
    );

    conversor_bin_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut10 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio10),
        .entrada (entrada10),
        .ocupado (ocupado10),
        .pronto  (pronto10),
`ifdef CONV_BCD_OVF_EN
        .estouro (estouro10),
`endif
        .bcd     (bcd10)
    );

`ifndef CONV_BCD_OVF_EN
    assign estouro8  = 1'b0;
    assign estouro10 = 1'b0;
`endif

    always #5 clk = ~clk;

    // Low three decimal digits of v, computed arithmetically.
    function automatic logic [11:0] ref_bcd(input int v);
        int r;
        logic [11:0] b;
        r = v;
        b = '0;
        for (int k = 0; k < 3; k++) begin
            b[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    task automatic start8(input logic [7:0] v);
        inicio8  = 1'b1;
        entrada8 = v;
        exp8_q.push_back(ref_bcd(int'(v)));
        @(posedge clk); #1;
        inicio8  = 1'b0;
        entrada8 = ~v;
    endtask

    task automatic start10(input logic [9:0] v);
        inicio10  = 1'b1;
        entrada10 = v;
        exp10_q.push_back(ref_bcd(int'(v)));
        ovf10_q.push_back(int'(v) >= 1000);
        @(posedge clk); #1;
        inicio10  = 1'b0;
        entrada10 = ~v;
    endtask

    task automatic wait_done(input bit wide, output int busy);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (wide ? pronto10 : pronto8) return;
            if (wide ? ocupado10 : ocupado8) busy++;
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL timeout wide=%0d: pronto never rose within 40 cycles, required 1", wide);
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({ocupado8, pronto8, bcd8, estouro8} !== 15'h0) begin
            errors++;
            $display("FAIL reset8: got oc=%b pr=%b bcd=%h ov=%b, required all 0", ocupado8, pronto8, bcd8, estouro8);
        end
        checks++;
        if ({ocupado10, pronto10, bcd10, estouro10} !== 15'h0) begin
            errors++;
            $display("FAIL reset10: got oc=%b pr=%b bcd=%h ov=%b, required all 0", ocupado10, pronto10, bcd10, estouro10);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int busy;
        logic [11:0] e;
        start8(8'd255);
        wait_done(1'b0, busy);
        checks++;
        if (busy !== 8) begin
            errors++; $display("FAIL basic_busy: got %0d cycles, required 8", busy);
        end
        e = exp8_q.pop_front();
        checks++;
        if (bcd8 !== e || e !== 12'h255) begin
            errors++; $display("FAIL basic_bcd: got %h, required %h", bcd8, e);
        end
        @(posedge clk); #1;
        checks++;
        if (pronto8 !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: got pronto=%b, required 0", pronto8);
        end
    endtask

    task automatic test_back_to_back;
        int busy;
        logic [11:0] e;
        logic [7:0] vals[3];
        vals = '{8'd0, 8'd99, 8'd100};
        for (int n = 0; n < 3; n++) begin
            start8(vals[n]);
            checks++;
            if (ocupado8 !== 1'b1) begin
                errors++; $display("FAIL b2b_accept%0d: got ocupado=%b, required 1", n, ocupado8);
            end
            wait_done(1'b0, busy);
            checks++;
            if (busy !== 8) begin
                errors++; $display("FAIL b2b_busy%0d: got %0d cycles, required 8", n, busy);
            end
            e = exp8_q.pop_front();
            checks++;
            if (bcd8 !== e) begin
                errors++; $display("FAIL b2b_bcd%0d: got %h, required %h", n, bcd8, e);
            end
            @(posedge clk); #1;
            checks++;
            if (pronto8 !== 1'b0 || ocupado8 !== 1'b0) begin
                errors++; $display("FAIL b2b_idle%0d: got pr=%b oc=%b, required 0 0", n, pronto8, ocupado8);
            end
        end
    endtask

    task automatic test_held_inicio;
        int seen;
        logic [11:0] e;
        logic [7:0] v;
        seen = 0;
        inicio8  = 1'b1;
        entrada8 = 8'd42;
        exp8_q.push_back(ref_bcd(42));
        @(posedge clk); #1;
        for (int i = 0; i < 22; i++) begin
            v = 8'(50 + 13 * i);
            if (i == 9) exp8_q.push_back(ref_bcd(int'(v)));
            entrada8 = v;
            if (i == 10) inicio8 = 1'b0;
            if (pronto8) begin
                seen++;
                e = exp8_q.pop_front();
                checks++;
                if (bcd8 !== e) begin
                    errors++; $display("FAIL held_bcd%0d: got %h, required %h", seen, bcd8, e);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 2) begin
            errors++; $display("FAIL held_count: got %0d results, required 2", seen);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        start8(8'd200);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        void'(exp8_q.pop_back());
        checks++;
        if ({ocupado8, pronto8, bcd8} !== 14'h0) begin
            errors++; $display("FAIL midreset: got oc=%b pr=%b bcd=%h, required all 0", ocupado8, pronto8, bcd8);
        end
        #3 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (pronto8 !== 1'b0 || ocupado8 !== 1'b0 || bcd8 !== 12'h000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL midreset_quiet: got %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_wide;
        int busy;
        logic [11:0] e;
        logic o;
        logic [9:0] vals[2];
        vals = '{10'd1023, 10'd999};
        for (int n = 0; n < 2; n++) begin
            start10(vals[n]);
            wait_done(1'b1, busy);
            checks++;
            if (busy !== 10) begin
                errors++; $display("FAIL wide_busy%0d: got %0d cycles, required 10", n, busy);
            end
            e = exp10_q.pop_front();
            o = ovf10_q.pop_front();
            checks++;
            if (bcd10 !== e) begin
                errors++; $display("FAIL wide_bcd%0d: got %h, required %h", n, bcd10, e);
            end
`ifdef CONV_BCD_OVF_EN
            checks++;
            if (estouro10 !== o) begin
                errors++; $display("FAIL wide_ovf%0d: got %b, required %b", n, estouro10, o);
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep8;
        int ord[256];
        int j, t, busy;
        logic [11:0] e;
        for (int i = 0; i < 256; i++) ord[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            start8(8'(ord[i]));
            wait_done(1'b0, busy);
            e = exp8_q.pop_front();
            checks++;
            if (bcd8 !== e || busy !== 8) begin
                errors++; $display("FAIL sweep8 v=%0d: got bcd=%h busy=%0d, required %h 8", ord[i], bcd8, busy, e);
            end
            @(posedge clk); #1;
            checks++;
            if (pronto8 !== 1'b0) begin
                errors++; $display("FAIL sweep8_pulse v=%0d: got pronto=%b, required 0", ord[i], pronto8);
            end
        end
    endtask

    task automatic test_sweep10;
        int busy;
        logic [11:0] e;
        logic o;
        for (int i = 0; i < 1024; i++) begin
            start10(10'(i));
            wait_done(1'b1, busy);
            e = exp10_q.pop_front();
            o = ovf10_q.pop_front();
            checks++;
            if (bcd10 !== e) begin
                errors++; $display("FAIL sweep10 v=%0d: got %h, required %h", i, bcd10, e);
            end
`ifdef CONV_BCD_OVF_EN
            checks++;
            if (estouro10 !== o) begin
                errors++; $display("FAIL sweep10_ovf v=%0d: got %b, required %b", i, estouro10, o);
            end
`endif
            @(posedge clk); #1;
            checks++;
            if (pronto10 !== 1'b0) begin
                errors++; $display("FAIL sweep10_pulse v=%0d: got pronto=%b, required 0", i, pronto10);
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        inicio8   = 1'b0;
        inicio10  = 1'b0;
        entrada8  = 8'd0;
        entrada10 = 10'd0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_held_inicio;
        test_reset_mid;
        test_wide;
        test_sweep8;
        test_sweep10;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
